// File: rtl/adc_sample_averager.sv
// adc_sample_averager: averages non-overlapping windows of 2^LOG2_AVG accepted
// ADC codes into a rounded result, flags windows containing a full-scale code,
// and queues results in a 2-entry valid/ready FIFO with a sticky overrun flag.
module adc_sample_averager #(
    parameter int DATA_W   = 8,
    parameter int LOG2_AVG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              out_ready,
    input  logic              clr_overrun,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_clip,
    output logic              avg_valid,
    output logic              overrun
);

    // Wide enough to hold 2^LOG2_AVG full-scale codes plus the rounding bias.
    localparam int ACC_W = DATA_W + LOG2_AVG;
    localparam logic [ACC_W-1:0] ROUND_K = ACC_W'(1) << (LOG2_AVG - 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              clip;
    } entry_t;

    // Window accumulation state
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [LOG2_AVG-1:0] cnt_q, cnt_d;
    logic                clip_q, clip_d;

    // FIFO state: slot0 is always the head, slot1 the second entry
    entry_t              slot0_q, slot0_d;
    entry_t              slot1_q, slot1_d;
    logic [1:0]          count_q, count_d;
    logic                overrun_q, overrun_d;

    logic                sample_full;
    logic                push;
    logic                pop;
    logic                drop;
    logic [ACC_W-1:0]    sum;
    entry_t              new_entry;

    assign sample_full = (sample_in == {DATA_W{1'b1}});
    assign push        = sample_valid && (cnt_q == {LOG2_AVG{1'b1}});
    assign pop         = (count_q != 2'd0) && out_ready;
    assign sum         = acc_q + ACC_W'(sample_in);

    // Rounded window average: add half an LSB of the result, then drop LOG2_AVG bits.
    assign new_entry.data = DATA_W'((sum + ROUND_K) >> LOG2_AVG);
    assign new_entry.clip = clip_q | sample_full;

    // Accumulator, sample counter and clip tracker advance on accepted samples only.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        clip_d = clip_q;
        if (push) begin
            acc_d  = '0;
            cnt_d  = '0;
            clip_d = 1'b0;
        end else if (sample_valid) begin
            acc_d  = sum;
            cnt_d  = cnt_q + LOG2_AVG'(1);
            clip_d = clip_q | sample_full;
        end
    end

    // FIFO next state: shift on pop, append on push, drop when full without a pop.
    always_comb begin
        slot0_d   = slot0_q;
        slot1_d   = slot1_q;
        count_d   = count_q;
        drop      = 1'b0;
        unique case ({push, pop})
            2'b11: begin
                if (count_q == 2'd1) begin
                    slot0_d = new_entry;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = new_entry;
                end
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    slot0_d = new_entry;
                    count_d = 2'd1;
                end else if (count_q == 2'd1) begin
                    slot1_d = new_entry;
                    count_d = 2'd2;
                end else begin
                    drop = 1'b1;
                end
            end
            default: ;
        endcase
        // A drop on the same edge as a clear wins so the loss is never hidden.
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            clip_q    <= 1'b0;
            // NOTE: the FIFO slots are reset too, because slot0 drives avg_out/avg_clip directly and they must read 0 out of reset.
            slot0_q   <= '0;
            slot1_q   <= '0;
            count_q   <= 2'd0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the pre-edge values of the others.
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            clip_q    <= clip_d;
            slot0_q   <= slot0_d;
            slot1_q   <= slot1_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign avg_out   = slot0_q.data;
    assign avg_clip  = slot0_q.clip;
    assign avg_valid = (count_q != 2'd0);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed testbench for adc_sample_averager (DATA_W=8, LOG2_AVG=4).
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_adc_sample_averager;

    localparam int DATA_W   = 8;
    localparam int LOG2_AVG = 4;
    localparam int WIN      = 1 << LOG2_AVG;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              out_ready;
    logic              clr_overrun;
    logic [DATA_W-1:0] avg_out;
    logic              avg_clip;
    logic              avg_valid;
    logic              overrun;

    int tests_run    = 0;
    int tests_failed = 0;

    adc_sample_averager #(
        .DATA_W  (DATA_W),
        .LOG2_AVG(LOG2_AVG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .out_ready   (out_ready),
        .clr_overrun (clr_overrun),
        .avg_out     (avg_out),
        .avg_clip    (avg_clip),
        .avg_valid   (avg_valid),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard bound on total run time.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; returns 1 unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed n consecutive accepted samples of value v, then idle the input.
    task automatic send(input logic [DATA_W-1:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            sample_in    = v;
            sample_valid = 1'b1;
            step();
        end
        sample_valid = 1'b0;
    endtask

    initial begin
        int early_valid;

        rst_n        = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        out_ready    = 1'b1;
        clr_overrun  = 1'b0;
        step();
        step();
        check("reset_valid", avg_valid, 0);
        check("reset_out", avg_out, 0);
        check("reset_clip", avg_clip, 0);
        check("reset_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 16 x 100: valid exactly after the 16th accept
        send(8'd100, 15);
        check("const100_not_early", avg_valid, 0);
        send(8'd100, 1);
        check("const100_valid", avg_valid, 1);
        check("const100_out", avg_out, 100);
        check("const100_clip", avg_clip, 0);
        step();
        check("const100_popped", avg_valid, 0);

        // Ramp 0..15: sum 120, 120/16 = 7.5 -> 8
        for (int i = 0; i < WIN; i++) begin
            sample_in    = DATA_W'(i);
            sample_valid = 1'b1;
            step();
        end
        sample_valid = 1'b0;
        check("ramp_out", avg_out, 8);
        step();

        // 15 x 0 then 8: sum 8, 0.5 rounds up to 1
        send(8'd0, 15);
        send(8'd8, 1);
        check("half_up_out", avg_out, 1);
        step();

        // Full scale, then tracker must be clear for the next window
        send(8'd255, WIN);
        check("fs_out", avg_out, 255);
        check("fs_clip", avg_clip, 1);
        step();
        send(8'd10, WIN);
        check("after_fs_out", avg_out, 10);
        check("after_fs_clip", avg_clip, 0);
        step();

        // Gapped valid: 16 accepts over 31 cycles
        early_valid = 0;
        for (int i = 0; i < WIN; i++) begin
            sample_in    = 8'd50;
            sample_valid = 1'b1;
            step();
            if (i < WIN - 1) begin
                if (avg_valid) early_valid++;
                sample_valid = 1'b0;
                step();
                if (avg_valid) early_valid++;
            end
        end
        sample_valid = 1'b0;
        check("gap_no_early", early_valid, 0);
        check("gap_valid", avg_valid, 1);
        check("gap_out", avg_out, 50);
        step();
        check("gap_single_result", avg_valid, 0);

        // Backpressure: 20 and 40 held, 60 dropped
        out_ready = 1'b0;
        send(8'd20, WIN);
        check("bp_head_20", avg_out, 20);
        send(8'd40, WIN);
        check("bp_hold_20", avg_out, 20);
        check("bp_no_overrun", overrun, 0);
        send(8'd60, WIN);
        check("bp_overrun", overrun, 1);
        check("bp_still_20", avg_out, 20);
        out_ready = 1'b1;
        step();
        check("bp_then_40", avg_out, 40);
        check("bp_then_40_valid", avg_valid, 1);
        step();
        check("bp_drained", avg_valid, 0);
        check("bp_overrun_sticky", overrun, 1);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        check("bp_cleared", overrun, 0);

        // Clear coinciding with a drop: set wins
        out_ready = 1'b0;
        send(8'd5, WIN);
        send(8'd6, WIN);
        send(8'd7, WIN - 1);
        clr_overrun = 1'b1;
        send(8'd7, 1);
        clr_overrun = 1'b0;
        check("clr_vs_drop", overrun, 1);
        out_ready = 1'b1;
        step();
        check("clr_vs_drop_head6", avg_out, 6);
        step();
        check("clr_vs_drop_drained", avg_valid, 0);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        check("clr_vs_drop_cleared", overrun, 0);

        // Full FIFO with pop on the edge a third result arrives
        out_ready = 1'b0;
        send(8'd11, WIN);
        send(8'd22, WIN);
        send(8'd33, WIN - 1);
        out_ready = 1'b1;
        send(8'd33, 1);
        check("full_pop_no_overrun", overrun, 0);
        check("full_pop_head22", avg_out, 22);
        check("full_pop_valid", avg_valid, 1);
        step();
        check("full_pop_head33", avg_out, 33);
        check("full_pop_valid33", avg_valid, 1);
        step();
        check("full_pop_drained", avg_valid, 0);

        // Reset mid-window with pending results and overrun set
        out_ready = 1'b0;
        send(8'd200, WIN);
        send(8'd200, WIN);
        send(8'd200, WIN);
        check("pre_rst_overrun", overrun, 1);
        send(8'd200, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", avg_valid, 0);
        check("async_rst_out", avg_out, 0);
        check("async_rst_clip", avg_clip, 0);
        check("async_rst_overrun", overrun, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(8'd30, 9);
        check("rst_partial_discarded", avg_valid, 0);
        send(8'd30, 7);
        check("rst_new_window_valid", avg_valid, 1);
        check("rst_new_window_out", avg_out, 30);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
